dbus_arbiter: RTL and testbench

//  Two-master arbiter for the shared data bus in front of wishbone_buf_if (data_ram + clint).

---
 rtl/dbus_pkg.sv | 14 +
 rtl/rr_pick2.sv | 24 ++
 rtl/dbus_arbiter.sv | 117 +++++++++++
 tb/tb_dbus_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared state and master-index constants for the data-bus arbiter
package dbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dbus_state_e;

  localparam logic M_CPU  = 1'b0;
  localparam logic M_DBG  = 1'b1;
  localparam int   LOCK_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick with a sticky override for the debug master
module rr_pick2
  import dbus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_ok,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = M_CPU;
    case (req)
      2'b01:   gnt = M_CPU;
      2'b10:   gnt = M_DBG;
      // On a tie the master that did not go last wins, unless m1 holds a live lock.
      2'b11:   gnt = (last == M_DBG && lock_ok) ? M_DBG : ~last;
      default: gnt = M_CPU;
    endcase
  end

endmodule

// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - two-master arbiter running one 2-cycle access at a time on the shared data bus
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              s_ce_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [3:0]        s_sel_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i
);

  localparam logic [LOCK_W-1:0] LOCK_MAX_C = LOCK_W'(LOCK_MAX);

  dbus_state_e       state, state_nxt;
  logic              gnt;
  logic              last;
  logic [LOCK_W-1:0] lock_cnt;
  logic [DATA_W-1:0] rbuf;
  logic              pick_gnt, pick_valid, lock_ok, arb_en, grant;

  assign lock_ok = m1_lock_i && (lock_cnt < LOCK_MAX_C);
  assign arb_en  = (state != ACCESS);
  assign grant   = arb_en && pick_valid;

  rr_pick2 u_pick (
    .req    ({m1_req_i, m0_req_i}),
    .last   (last),
    .lock_ok(lock_ok),
    .gnt    (pick_gnt),
    .valid  (pick_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RESP: state_nxt = pick_valid ? ACCESS : IDLE;
      ACCESS:     state_nxt = RESP;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= M_CPU;
      last     <= M_DBG;
      lock_cnt <= '0;
      rbuf     <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt  <= pick_gnt;
        last <= pick_gnt;
        // Only a back-to-back m1 grant under lock extends the run; anything else restarts it.
        if (pick_gnt == M_DBG && last == M_DBG && m1_lock_i)
          lock_cnt <= (lock_cnt == LOCK_MAX_C) ? lock_cnt : lock_cnt + 1'b1;
        else
          lock_cnt <= '0;
      end
      if (state == ACCESS)
        rbuf <= s_rdata_i;
    end
  end

  always_comb begin
    s_ce_o    = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_sel_o   = '0;
    s_wdata_o = '0;
    if (state == ACCESS) begin
      s_ce_o = 1'b1;
      if (gnt == M_DBG) begin
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_sel_o   = m1_sel_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_we_o    = m0_we_i;
        s_addr_o  = m0_addr_i;
        s_sel_o   = m0_sel_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  assign m0_ack_o   = (state == RESP) && (gnt == M_CPU);
  assign m1_ack_o   = (state == RESP) && (gnt == M_DBG);
  assign m0_rdata_o = m0_ack_o ? rbuf : '0;
  assign m1_rdata_o = m1_ack_o ? rbuf : '0;
  // Gated by reset so every output reads 0 while reset is held.
  assign m0_stall_o = rst & m0_req_i & ~m0_ack_o;

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb/tb_dbus_arbiter.sv - self-checking bench for dbus_arbiter
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
  logic [3:0]  m0_sel_i = '0;
  logic [31:0] m0_rdata_o;
  logic        m0_ack_o, m0_stall_o;
  logic        m1_req_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
  logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
  logic [3:0]  m1_sel_i = '0;
  logic [31:0] m1_rdata_o;
  logic        m1_ack_o;
  logic        s_ce_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_rdata_i = '0;

  always #5 clk = ~clk;

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_sel_i(m0_sel_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_sel_i(m1_sel_i),
    .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
    .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_sel_o(s_sel_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  int t, k;
  bit chk_en = 1'b0;

  // Schedule model: an access occupies cycle acc_cyc, its response acc_cyc+1.
  int          acc_cyc = -10;
  bit          acc_who = 1'b0;
  bit          m_last = 1'b1;
  int          streak = 0;
  logic [31:0] exp_rbuf = '0;
  bit          p_rst = 1'b0, p_lock = 1'b0;
  bit   [1:0]  p_req = '0;
  logic [31:0] p_srd = '0;

  int          remaining [2] = '{0, 0};
  bit          vary_srd = 1'b1;
  logic [31:0] srd_val = 32'h5A5A_0000;

  int          ack_cyc_q[$];
  bit          ack_who_q[$];
  logic [31:0] ack_rd_q[$];
  int          ce_cyc_q[$];
  logic [69:0] ce_q[$];
  int          stall_cycles = 0, stall_last = -1, we_cycles = 0;

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [136:0] all_outs();
    return {s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o,
            m0_ack_o, m0_rdata_o, m0_stall_o, m1_ack_o, m1_rdata_o};
  endfunction

  task automatic model_step();
    bit w;
    if (!p_rst) begin
      acc_cyc = -10; m_last = 1'b1; streak = 0;
    end else begin
      if (cyc - 1 == acc_cyc) exp_rbuf = p_srd;
      if (cyc - 1 != acc_cyc && p_req != 2'b00) begin
        if (p_req == 2'b01)      w = 1'b0;
        else if (p_req == 2'b10) w = 1'b1;
        else                     w = (m_last && p_lock && streak < 15) ? 1'b1 : !m_last;
        if (w && m_last && p_lock) streak = (streak < 15) ? streak + 1 : 15;
        else                       streak = 0;
        m_last  = w;
        acc_who = w;
        acc_cyc = cyc;
      end
    end
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++)
      if (rst && cyc == acc_cyc + 1 && int'(acc_who) == m && remaining[m] > 0) remaining[m]--;
    m0_req_i  = remaining[0] > 0;
    m1_req_i  = remaining[1] > 0;
    s_rdata_i = vary_srd ? (srd_val ^ 32'(cyc)) : srd_val;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      drive();
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [69:0] es;
    logic [33:0] e0;
    logic [32:0] e1;
    bit acc_now, ack0, ack1;
    if (chk_en) begin
      acc_now = rst && (cyc == acc_cyc);
      ack0    = rst && (cyc == acc_cyc + 1) && !acc_who;
      ack1    = rst && (cyc == acc_cyc + 1) && acc_who;
      es = !acc_now ? 70'd0 :
           acc_who  ? {1'b1, m1_we_i, m1_addr_i, m1_sel_i, m1_wdata_i}
                    : {1'b1, m0_we_i, m0_addr_i, m0_sel_i, m0_wdata_i};
      e0 = {ack0, ack0 ? exp_rbuf : 32'h0, rst & m0_req_i & ~ack0};
      e1 = {ack1, ack1 ? exp_rbuf : 32'h0};
      check("slave_bus", 160'({s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o}), 160'(es));
      check("m0_outs", 160'({m0_ack_o, m0_rdata_o, m0_stall_o}), 160'(e0));
      check("m1_outs", 160'({m1_ack_o, m1_rdata_o}), 160'(e1));
      if (m0_ack_o) begin ack_cyc_q.push_back(cyc); ack_who_q.push_back(1'b0); ack_rd_q.push_back(m0_rdata_o); end
      if (m1_ack_o) begin ack_cyc_q.push_back(cyc); ack_who_q.push_back(1'b1); ack_rd_q.push_back(m1_rdata_o); end
      if (s_ce_o) begin ce_cyc_q.push_back(cyc); ce_q.push_back({s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o}); end
      if (m0_stall_o) begin stall_cycles++; stall_last = cyc; end
      if (s_we_o) we_cycles++;
    end
    p_rst  = rst;
    p_req  = {m1_req_i, m0_req_i};
    p_lock = m1_lock_i;
    p_srd  = s_rdata_i;
  end

  task automatic do_reset();
    rst = 1'b0;
    remaining = '{0, 0};
    m1_lock_i = 1'b0;
    step(1);
    #1 check("reset_outs", 160'(all_outs()), 160'(0));
    step(1);
    rst = 1'b1;
    ack_cyc_q.delete(); ack_who_q.delete(); ack_rd_q.delete();
    ce_cyc_q.delete(); ce_q.delete();
    stall_cycles = 0; stall_last = -1; we_cycles = 0;
  endtask

  initial begin
    chk_en = 1'b1;

    // 1: single m0 read
    do_reset();
    vary_srd = 1'b0; srd_val = 32'hDEAD_BEEF;
    m0_we_i = 1'b0; m0_addr_i = 32'h0000_0010; m0_sel_i = 4'hF; m0_wdata_i = '0;
    remaining[0] = 1;
    step(1); t = cyc;
    step(5);
    check("s1_ce_count", 160'(ce_cyc_q.size()), 160'(1));
    if (ce_cyc_q.size() > 0) check("s1_ce_cyc", 160'(ce_cyc_q[0] - t), 160'(1));
    if (ce_q.size() > 0) check("s1_addr", 160'(ce_q[0][67:36]), 160'(32'h0000_0010));
    check("s1_ack_count", 160'(ack_cyc_q.size()), 160'(1));
    if (ack_cyc_q.size() > 0) begin
      check("s1_ack_cyc", 160'(ack_cyc_q[0] - t), 160'(2));
      check("s1_rdata", 160'(ack_rd_q[0]), 160'(32'hDEAD_BEEF));
    end
    vary_srd = 1'b1; srd_val = 32'h5A5A_0000;

    // 2: both masters from reset alternate, m0 first
    do_reset();
    m0_addr_i = 32'h0000_0100; m1_addr_i = 32'h0000_0200; m1_we_i = 1'b0; m1_sel_i = 4'hF;
    remaining = '{2, 2};
    step(1); t = cyc;
    step(10);
    check("s2_ack_count", 160'(ack_cyc_q.size()), 160'(4));
    for (int i = 0; i < 4 && i < ack_cyc_q.size(); i++) begin
      check("s2_ack_cyc", 160'(ack_cyc_q[i] - t), 160'(2 * i + 2));
      check("s2_ack_who", 160'(ack_who_q[i]), 160'(i % 2));
    end
    check("s2_drained", 160'(remaining[0] + remaining[1]), 160'(0));

    // 3: m1 lock holds the bus for 15 grants, then m0 gets in
    do_reset();
    m1_lock_i = 1'b1;
    remaining = '{1, 20};
    step(1); t = cyc;
    step(48);
    m1_lock_i = 1'b0;
    k = -1;
    foreach (ack_who_q[i]) if (k < 0 && ack_who_q[i] == 1'b0) k = i;
    check("s3_m1_run", 160'(k), 160'(15));
    if (k >= 0) check("s3_m0_cyc", 160'(ack_cyc_q[k] - t), 160'(32));
    check("s3_ack_total", 160'(ack_cyc_q.size()), 160'(21));
    check("s3_drained", 160'(remaining[0] + remaining[1]), 160'(0));

    // 4: m1 partial write
    do_reset();
    m1_we_i = 1'b1; m1_addr_i = 32'h0200_4000; m1_sel_i = 4'b0011; m1_wdata_i = 32'h0000_1234;
    remaining[1] = 1;
    step(1); t = cyc;
    step(5);
    check("s4_ce_count", 160'(ce_cyc_q.size()), 160'(1));
    check("s4_we_cycles", 160'(we_cycles), 160'(1));
    if (ce_q.size() > 0) begin
      check("s4_ce_cyc", 160'(ce_cyc_q[0] - t), 160'(1));
      check("s4_bus", 160'(ce_q[0]), 160'({1'b1, 1'b1, 32'h0200_4000, 4'b0011, 32'h0000_1234}));
    end
    m1_we_i = 1'b0;

    // 5: reset during ACCESS aborts; held request is served after release
    do_reset();
    m0_addr_i = 32'h0000_0040;
    remaining[0] = 1;
    step(1); t = cyc;
    step(1);
    rst = 1'b0;
    #1 check("s5_abort_outs", 160'(all_outs()), 160'(0));
    step(3);
    check("s5_no_ack", 160'(ack_cyc_q.size()), 160'(0));
    rst = 1'b1; t = cyc;
    step(4);
    check("s5_ack_count", 160'(ack_cyc_q.size()), 160'(1));
    if (ack_cyc_q.size() > 0) begin
      check("s5_ack_cyc", 160'(ack_cyc_q[0] - t), 160'(2));
      check("s5_ack_who", 160'(ack_who_q[0]), 160'(0));
    end

    // 6: m0 stalls behind an in-flight m1 access
    do_reset();
    remaining[1] = 2;
    step(1); t = cyc;
    remaining[0] = 1;
    step(9);
    check("s6_stall_cycles", 160'(stall_cycles), 160'(3));
    check("s6_stall_last", 160'(stall_last - t), 160'(3));
    k = -1;
    foreach (ack_who_q[i]) if (k < 0 && ack_who_q[i] == 1'b0) k = i;
    if (k >= 0) check("s6_m0_ack_cyc", 160'(ack_cyc_q[k] - t), 160'(4));
    else check("s6_m0_ack_seen", 160'(0), 160'(1));
    check("s6_drained", 160'(remaining[0] + remaining[1]), 160'(0));

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
